// File: rtl/fadd_rr_sched.sv
// rtl/fadd_rr_sched.sv - round-robin scheduler sharing one fixed-latency FP add datapath
// between two requesters, with tag pipeline routing results back to one-deep response slots.
module fadd_rr_sched #(
  parameter int W   = 37,
  parameter int LAT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [W-1:0] rsp0_data,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp1_data,
  output logic         dp_valid,
  output logic [W-1:0] dp_a,
  output logic [W-1:0] dp_b,
  input  logic [W-1:0] dp_res
);

  logic [1:0]   busy_q, busy_d;
  logic         last_grant_q, last_grant_d;
  logic [W-1:0] dp_a_q, dp_a_d, dp_b_q, dp_b_d;
  logic [LAT:0] tag_v_q, tag_v_d;
  logic [LAT:0] tag_id_q, tag_id_d;
  logic [1:0]   rsp_v_q, rsp_v_d;
  logic [W-1:0] rsp0_q, rsp0_d, rsp1_q, rsp1_d;
  logic [1:0]   elig, grant, rsp_hs;

  // Ready is held low during reset so no handshake can land on a reset edge.
  always_comb begin
    elig   = {req1_valid & ~busy_q[1], req0_valid & ~busy_q[0]} & {2{~rst}};
    rsp_hs = rsp_v_q & {rsp1_ready, rsp0_ready};
    grant  = elig;
    if (elig == 2'b11) begin
      grant = last_grant_q ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    dp_a_d       = dp_a_q;
    dp_b_d       = dp_b_q;
    rsp0_d       = rsp0_q;
    rsp1_d       = rsp1_q;
    busy_d       = (busy_q & ~rsp_hs) | grant;
    rsp_v_d      = rsp_v_q & ~rsp_hs;
    tag_v_d      = {tag_v_q[LAT-1:0], |grant};
    tag_id_d     = {tag_id_q[LAT-1:0], grant[1]};
    if (grant[0]) begin
      dp_a_d       = req0_a;
      dp_b_d       = req0_b;
      last_grant_d = 1'b0;
    end else if (grant[1]) begin
      dp_a_d       = req1_a;
      dp_b_d       = req1_b;
      last_grant_d = 1'b1;
    end
    // Last tag stage lines up with the cycle dp_res is valid.
    if (tag_v_q[LAT]) begin
      if (tag_id_q[LAT]) begin
        rsp_v_d[1] = 1'b1;
        rsp1_d     = dp_res;
      end else begin
        rsp_v_d[0] = 1'b1;
        rsp0_d     = dp_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= '0;
      last_grant_q <= 1'b1;
      dp_a_q       <= '0;
      dp_b_q       <= '0;
      tag_v_q      <= '0;
      tag_id_q     <= '0;
      rsp_v_q      <= '0;
      rsp0_q       <= '0;
      rsp1_q       <= '0;
    end else begin
      busy_q       <= busy_d;
      last_grant_q <= last_grant_d;
      dp_a_q       <= dp_a_d;
      dp_b_q       <= dp_b_d;
      tag_v_q      <= tag_v_d;
      tag_id_q     <= tag_id_d;
      rsp_v_q      <= rsp_v_d;
      rsp0_q       <= rsp0_d;
      rsp1_q       <= rsp1_d;
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign rsp0_valid = rsp_v_q[0];
  assign rsp1_valid = rsp_v_q[1];
  assign rsp0_data  = rsp0_q;
  assign rsp1_data  = rsp1_q;
  assign dp_valid   = tag_v_q[0];
  assign dp_a       = dp_a_q;
  assign dp_b       = dp_b_q;

endmodule

// File: tb/tb_fadd_rr_sched.sv
// tb/tb_fadd_rr_sched.sv - self-checking bench for fadd_rr_sched with a behavioural
// fixed-latency FP add datapath.
module tb_fadd_rr_sched;
  localparam int W   = 37;
  localparam int LAT = 3;
  localparam logic [W-1:0] JUNK = 37'h1_2345_6789;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic [W-1:0] req0_a, req0_b, rsp0_data;
  logic         req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [W-1:0] req1_a, req1_b, rsp1_data;
  logic         dp_valid;
  logic [W-1:0] dp_a, dp_b, dp_res;

  int n_checks = 0;
  int n_fail   = 0;

  fadd_rr_sched #(.W(W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .dp_valid(dp_valid), .dp_a(dp_a), .dp_b(dp_b), .dp_res(dp_res)
  );

  always #5 clk = ~clk;

  // Positive same-sign add with explicit leading one at mantissa bit 27.
  function automatic logic [W-1:0] fp_add(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] hi, lo;
    logic [7:0]   d, e;
    logic [28:0]  m;
    if (x[35:28] >= y[35:28]) begin hi = x; lo = y; end
    else begin hi = y; lo = x; end
    d = hi[35:28] - lo[35:28];
    e = hi[35:28];
    m = {1'b0, hi[27:0]} + ((d >= 8'd28) ? 29'd0 : ({1'b0, lo[27:0]} >> d));
    if (m[28]) begin
      m = m >> 1;
      e = e + 8'd1;
    end
    return {hi[36], e, m[27:0]};
  endfunction

  // Datapath model is never reset, so results of discarded ops still arrive late.
  logic [W-1:0]   pipe_d [LAT];
  logic [LAT-1:0] pipe_v = '0;
  always @(posedge clk) begin
    pipe_v    <= {pipe_v[LAT-2:0], dp_valid};
    pipe_d[0] <= fp_add(dp_a, dp_b);
    for (int i = 1; i < LAT; i++) pipe_d[i] <= pipe_d[i-1];
  end
  assign dp_res = pipe_v[LAT-1] ? pipe_d[LAT-1] : JUNK;

  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;
  vec_t vecs [6];

  function automatic logic [W-1:0] fpv(input logic [7:0] e, input logic [27:0] m);
    return {1'b0, e, m};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input logic id);
    return id ? req1_ready : req0_ready;
  endfunction
  function automatic logic rv(input logic id);
    return id ? rsp1_valid : rsp0_valid;
  endfunction
  function automatic logic [W-1:0] rd(input logic id);
    return id ? rsp1_data : rsp0_data;
  endfunction

  task automatic drive_req(input logic id, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    if (id) begin req1_valid = v; req1_a = a; req1_b = b; end
    else begin req0_valid = v; req0_a = a; req0_b = b; end
  endtask

  task automatic set_rr(input logic id, input logic v);
    if (id) rsp1_ready = v;
    else rsp0_ready = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic run_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] e);
    int n;
    drive_req(id, 1'b1, a, b);
    #1;
    checkb("issue_ready", rdy(id), 1'b1);
    step();
    drive_req(id, 1'b0, a, b);
    checkb("dp_valid", dp_valid, 1'b1);
    check("dp_a", dp_a, a);
    check("dp_b", dp_b, b);
    n = 1;
    while (!rv(id) && n < 20) begin
      step();
      n++;
    end
    checki("rsp_latency", n, LAT + 2);
    check("rsp_data", rd(id), e);
    drive_req(id, 1'b1, a, b);
    set_rr(id, 1'b1);
    #1;
    checkb("no_bypass", rdy(id), 1'b0);
    step();
    set_rr(id, 1'b0);
    #1;
    checkb("rsp_cleared", rv(id), 1'b0);
    checkb("reissue_ready", rdy(id), 1'b1);
    drive_req(id, 1'b0, a, b);
    #1;
  endtask

  initial begin
    int n, held, prev, rises, cnt0, cnt1, bad;
    logic [W-1:0] hold_data;

    vecs[0] = '{1'b0, fpv(8'h86, 28'h8000000), fpv(8'h85, 28'h8000000), fpv(8'h86, 28'hC000000)};
    vecs[1] = '{1'b1, fpv(8'h80, 28'h8000000), fpv(8'h80, 28'h8000000), fpv(8'h81, 28'h8000000)};
    vecs[2] = '{1'b0, fpv(8'h7F, 28'hC000000), fpv(8'h7D, 28'h8000000), fpv(8'h7F, 28'hE000000)};
    vecs[3] = '{1'b1, fpv(8'h70, 28'h8000000), fpv(8'h90, 28'h8000000), fpv(8'h90, 28'h8000000)};
    vecs[4] = '{1'b0, fpv(8'h85, 28'hF000000), fpv(8'h85, 28'h9000000), fpv(8'h86, 28'hC000000)};
    vecs[5] = '{1'b1, fpv(8'h82, 28'hA000000), fpv(8'h81, 28'hC000000), fpv(8'h83, 28'h8000000)};

    // Reset with req0 already waiting.
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = vecs[0].a; req0_b = vecs[0].b;
    req1_valid = 1'b1; req1_a = vecs[1].a; req1_b = vecs[1].b;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    step();
    checkb("rst_req0_ready", req0_ready, 1'b0);
    checkb("rst_req1_ready", req1_ready, 1'b0);
    checkb("rst_dp_valid", dp_valid, 1'b0);
    checkb("rst_rsp0_valid", rsp0_valid, 1'b0);
    checkb("rst_rsp1_valid", rsp1_valid, 1'b0);
    check("rst_dp_a", dp_a, '0);
    check("rst_rsp0_data", rsp0_data, '0);
    step();
    rst = 1'b0;
    req1_valid = 1'b0;
    run_op(1'b0, vecs[0].a, vecs[0].b, vecs[0].exp);

    for (int i = 0; i < 6; i++) run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Tie after reset: req0 first, then req1; results must not cross.
    do_reset();
    drive_req(1'b0, 1'b1, vecs[2].a, vecs[2].b);
    drive_req(1'b1, 1'b1, vecs[3].a, vecs[3].b);
    #1;
    checkb("tie_ready0", req0_ready, 1'b1);
    checkb("tie_ready1", req1_ready, 1'b0);
    step();
    req0_valid = 1'b0;
    #1;
    checkb("tie_ready1_next", req1_ready, 1'b1);
    check("tie_dp_a0", dp_a, vecs[2].a);
    step();
    req1_valid = 1'b0;
    check("tie_dp_a1", dp_a, vecs[3].a);
    n = 0;
    while (!rsp1_valid && n < 20) begin step(); n++; end
    checkb("tie_rsp0_valid", rsp0_valid, 1'b1);
    checkb("tie_rsp1_valid", rsp1_valid, 1'b1);
    check("tie_rsp0_data", rsp0_data, vecs[2].exp);
    check("tie_rsp1_data", rsp1_data, vecs[3].exp);

    // Backpressure on rsp1 while req0 keeps streaming.
    do_reset();
    drive_req(1'b1, 1'b1, vecs[5].a, vecs[5].b);
    rsp0_ready = 1'b1;
    #1;
    checkb("bp_req1_issue", req1_ready, 1'b1);
    step();
    drive_req(1'b0, 1'b1, vecs[4].a, vecs[4].b);
    held = 0; prev = -1; bad = 0; hold_data = '0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (req1_ready) bad++;
      if (req0_ready) begin
        if (prev >= 0) checki("bp_req0_interval", k - prev, LAT + 3);
        prev = k;
      end
      if (rsp1_valid) begin
        if (held == 0) hold_data = rsp1_data;
        else if (rsp1_data !== hold_data) bad++;
        held++;
      end
      if (rsp0_valid && rsp0_data !== vecs[4].exp) bad++;
      step();
    end
    checki("bp_errors", bad, 0);
    checkb("bp_held_20", held >= 20, 1'b1);
    check("bp_rsp1_data", hold_data, vecs[5].exp);

    // Fairness with both requesters always pending.
    do_reset();
    drive_req(1'b0, 1'b1, vecs[0].a, vecs[0].b);
    drive_req(1'b1, 1'b1, vecs[1].a, vecs[1].b);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    cnt0 = 0; cnt1 = 0; bad = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (req0_ready) cnt0++;
      if (req1_ready) cnt1++;
      if (req0_ready && req1_ready) bad++;
      if (rsp0_valid && rsp0_data !== vecs[0].exp) bad++;
      if (rsp1_valid && rsp1_data !== vecs[1].exp) bad++;
      step();
    end
    checki("fair_errors", bad, 0);
    checki("fair_cnt0", cnt0, 17);
    checki("fair_cnt1", cnt1, 17);
    checkb("fair_diff", (cnt0 - cnt1 <= 1) && (cnt1 - cnt0 <= 1), 1'b1);

    // Reset two cycles after issue: the result must never surface.
    do_reset();
    drive_req(1'b0, 1'b1, vecs[2].a, vecs[2].b);
    #1;
    step();
    req0_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    rises = 0;
    for (int k = 0; k < 15; k++) begin
      if (rsp0_valid) rises++;
      step();
    end
    checki("midrst_no_rsp", rises, 0);
    run_op(1'b0, vecs[1].a, vecs[1].b, vecs[1].exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
